mux_nx1_xfade: RTL and testbench

Parametrised N-input registered signal multiplexer for the pt_feedback data path, the successor to the plain 2-way registered mux. A select change produces a linear crossfade from the old input to the new one over a fixed ramp instead of a hard step, which avoids transients in the feedback loop. A bypass input restores the immediate, hard-switch behaviour.

---
 rtl/mux_nx1_xfade.sv | 120 ++++++++++++
 tb/tb_mux_nx1_xfade.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_xfade.sv
// N-input registered mux with a linear crossfade on select change.
// bypass_i switches immediately or aborts a running fade.
module mux_nx1_xfade #(
  parameter  int WIDTH     = 16,
  parameter  int N_IN      = 4,
  parameter  int RAMP_BITS = 8,
  localparam int SEL_W     = $clog2(N_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    bypass_i,
  input  logic [N_IN*WIDTH-1:0]   in_flat_i,
  output logic signed [WIDTH-1:0] out_o,
  output logic                    busy_o,
  output logic [SEL_W-1:0]        sel_active_o
);

  localparam int M  = 1 << RAMP_BITS;
  localparam int PW = WIDTH + RAMP_BITS + 1;
  localparam logic [RAMP_BITS-1:0] LAST =
    RAMP_BITS'(M - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  state_t                  r_state;
  logic [SEL_W-1:0]        r_cur;
  logic [SEL_W-1:0]        r_tgt;
  logic [RAMP_BITS-1:0]    r_cnt;
  logic signed [WIDTH-1:0] r_out;

  logic signed [WIDTH-1:0] w_ch [N_IN];
  logic signed [WIDTH-1:0] w_cur;
  logic signed [WIDTH-1:0] w_tgt;
  logic                    w_sel_ok;
  logic                    w_req;
  logic signed [PW-1:0]    w_a;
  logic signed [PW-1:0]    w_b;
  logic signed [PW-1:0]    w_wa;
  logic signed [PW-1:0]    w_wb;
  logic signed [PW-1:0]    w_pa;
  logic signed [PW-1:0]    w_pb;
  logic signed [PW:0]      w_sum;
  logic signed [PW:0]      w_shr;
  logic signed [WIDTH-1:0] w_mix;
  logic                    w_unused;

  for (genvar k = 0; k < N_IN; k++) begin : g_ch
    assign w_ch[k] = in_flat_i[k*WIDTH +: WIDTH];
  end

  assign w_cur = w_ch[r_cur];
  assign w_tgt = w_ch[r_tgt];

  assign w_sel_ok = {1'b0, sel_i} < (SEL_W+1)'(N_IN);
  assign w_req    = w_sel_ok && (sel_i != r_cur);

  // Convex mix: weights sum to M, so the floor fits WIDTH.
  assign w_a   = PW'(w_cur);
  assign w_b   = PW'(w_tgt);
  assign w_wb  = {{(PW-RAMP_BITS){1'b0}}, r_cnt};
  assign w_wa  = PW'(M) - w_wb;
  assign w_pa  = w_a * w_wa;
  assign w_pb  = w_b * w_wb;
  assign w_sum = (PW+1)'(w_pa) + (PW+1)'(w_pb);
  assign w_shr = w_sum >>> RAMP_BITS;
  assign w_mix = w_shr[WIDTH-1:0];

  assign w_unused = ^w_shr[PW:WIDTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_out <= w_cur;
          if (w_req) begin
            if (bypass_i) begin
              r_cur <= sel_i;
            end else begin
              r_tgt   <= sel_i;
              r_cnt   <= RAMP_BITS'(1);
              r_state <= FADE;
            end
          end
        end
        FADE: begin
          r_out <= w_mix;
          priority case (1'b1)
            bypass_i: begin
              r_cur   <= w_sel_ok ? sel_i : r_tgt;
              r_cnt   <= '0;
              r_state <= IDLE;
            end
            (r_cnt == LAST): begin
              r_cur   <= r_tgt;
              r_cnt   <= '0;
              r_state <= IDLE;
            end
            default: r_cnt <= r_cnt + 1'b1;
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_o        = r_out;
  assign busy_o       = (r_state == FADE);
  assign sel_active_o = r_cur;

endmodule

// File: tb/tb_mux_nx1_xfade.sv
// Bench for mux_nx1_xfade: directed steps plus random traffic
// checked against an arithmetic reference of the crossfade.
module tb_mux_nx1_xfade;

  localparam int W  = 16;
  localparam int N  = 3;
  localparam int R  = 2;
  localparam int M  = 4;
  localparam int SW = 2;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic [SW-1:0]       sel;
  logic                bypass;
  logic signed [W-1:0] in_v [N];
  logic [N*W-1:0]      in_flat;
  logic signed [W-1:0] out_o;
  logic                busy_o;
  logic [SW-1:0]       sel_active;

  int n_pass  = 0;
  int n_total = 0;

  int m_cur, m_tgt, m_cnt, m_out;
  bit m_fade;

  int exp_a [5] = '{100, 50, 0, -50, -100};
  int exp_b [5] = '{1, 1, 1, 0, 0};
  int exp_s [5] = '{0, 0, 0, 1, 1};
  int exp_f1 [5] = '{0, -1, -1, -1, -1};
  int exp_f2 [5] = '{0, 0, 1, 2, 3};

  assign in_flat = {in_v[2], in_v[1], in_v[0]};

  always #5 clk = ~clk;

  mux_nx1_xfade #(
    .WIDTH(W),
    .N_IN(N),
    .RAMP_BITS(R)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .sel_i(sel),
    .bypass_i(bypass),
    .in_flat_i(in_flat),
    .out_o(out_o),
    .busy_o(busy_o),
    .sel_active_o(sel_active)
  );

  function automatic int fdiv(int n, int d);
    int q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  task automatic chk(string tag, int got, int exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d",
                tag, got, exp);
  endtask

  task automatic model_reset();
    m_cur  = 0;
    m_tgt  = 0;
    m_cnt  = 0;
    m_fade = 0;
    m_out  = 0;
  endtask

  // Next output and committed channel from the current inputs.
  task automatic model_step();
    int s;
    bit ok;
    int a, b;
    s  = int'(sel);
    ok = (s < N);
    if (!m_fade) begin
      m_out = int'(in_v[m_cur]);
      if (ok && s != m_cur) begin
        if (bypass) m_cur = s;
        else begin
          m_tgt  = s;
          m_cnt  = 1;
          m_fade = 1;
        end
      end
    end else begin
      a = int'(in_v[m_cur]);
      b = int'(in_v[m_tgt]);
      m_out = fdiv(a * (M - m_cnt) + b * m_cnt, M);
      if (bypass) begin
        m_cur  = ok ? s : m_tgt;
        m_fade = 0;
        m_cnt  = 0;
      end else if (m_cnt == M - 1) begin
        m_cur  = m_tgt;
        m_fade = 0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_out", int'(out_o), m_out);
    chk("model_busy", int'(busy_o), int'(m_fade));
    chk("model_sel", int'(sel_active), m_cur);
  endtask

  initial begin
    rst_ni  = 1'b0;
    bypass  = 1'b0;
    sel     = 2'd2;
    in_v[0] = 16'sd11;
    in_v[1] = 16'sd22;
    in_v[2] = 16'sd33;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", int'(out_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_sel", int'(sel_active), 0);

    rst_ni = 1'b1;
    tick();
    chk("post_rst_out", int'(out_o), 11);
    chk("post_rst_busy", int'(busy_o), 1);
    repeat (4) tick();
    chk("post_rst_sel", int'(sel_active), 2);

    in_v[0] = 16'sd100;
    in_v[1] = -16'sd100;
    sel = 2'd0;
    repeat (6) tick();
    sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fade_out", int'(out_o), exp_a[i]);
      chk("fade_busy", int'(busy_o), exp_b[i]);
      chk("fade_sel", int'(sel_active), exp_s[i]);
    end

    in_v[0] = 16'sd0;
    in_v[1] = -16'sd1;
    sel = 2'd0;
    repeat (6) tick();
    sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("floor_neg", int'(out_o), exp_f1[i]);
    end
    sel = 2'd0;
    repeat (6) tick();
    in_v[1] = 16'sd3;
    sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("floor_pos", int'(out_o), exp_f2[i]);
    end

    in_v[2] = 16'sd1234;
    bypass = 1'b1;
    sel = 2'd2;
    tick();
    chk("byp_old", int'(out_o), 3);
    chk("byp_busy0", int'(busy_o), 0);
    tick();
    chk("byp_new", int'(out_o), 1234);
    chk("byp_busy1", int'(busy_o), 0);
    chk("byp_sel", int'(sel_active), 2);

    bypass = 1'b0;
    in_v[0] = 16'sd400;
    sel = 2'd0;
    tick();
    chk("abort_busy_a", int'(busy_o), 1);
    tick();
    bypass = 1'b1;
    tick();
    chk("abort_busy_b", int'(busy_o), 0);
    chk("abort_mix", int'(out_o), 817);
    tick();
    chk("abort_pure", int'(out_o), 400);
    chk("abort_sel", int'(sel_active), 0);

    bypass = 1'b0;
    sel = 2'd1;
    tick();
    sel = 2'd2;
    repeat (3) tick();
    chk("chain_busy_a", int'(busy_o), 0);
    chk("chain_sel_a", int'(sel_active), 1);
    tick();
    chk("chain_busy_b", int'(busy_o), 1);
    repeat (4) tick();
    chk("chain_sel_b", int'(sel_active), 2);

    sel = 2'd3;
    repeat (3) tick();
    chk("inv_busy", int'(busy_o), 0);
    chk("inv_sel", int'(sel_active), 2);
    chk("inv_out", int'(out_o), 1234);

    repeat (400) begin
      for (int k = 0; k < N; k++) in_v[k] = W'($urandom);
      sel    = SW'($urandom_range(0, 3));
      bypass = ($urandom_range(0, 7) == 0);
      tick();
    end

    bypass = 1'b1;
    sel = 2'd0;
    tick();
    bypass = 1'b0;
    sel = 2'd1;
    tick();
    tick();
    chk("mid_busy", int'(busy_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_out", int'(out_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_sel", int'(sel_active), 0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
